// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator with raster counters and an IDLE/RUN/DRAIN enable FSM.
// Sync, data enable, pixel and start-of-frame outputs are registered one clock behind the counters.
module video_pattern_gen #(
    parameter int   H_ACTIVE = 160,
    parameter int   H_FP     = 8,
    parameter int   H_SYNC   = 32,
    parameter int   H_BP     = 40,
    parameter int   V_ACTIVE = 120,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 6,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   DW       = 8,
    parameter int   CHK_LOG2 = 3
) (
    input  logic            I_pxl_clk,
    input  logic            I_rst_n,
    input  logic            I_en,
    input  logic [2:0]      I_mode,
    input  logic [3*DW-1:0] I_solid_rgb,
    output logic            O_rgb_vs,
    output logic            O_rgb_hs,
    output logic            O_rgb_de,
    output logic [DW-1:0]   O_rgb_r,
    output logic [DW-1:0]   O_rgb_g,
    output logic [DW-1:0]   O_rgb_b,
    output logic            O_sof,
    output logic [15:0]     O_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter widths also hold the *_TOTAL value and the checker bit.
    localparam int HW_RAW = $clog2(H_TOTAL + 1);
    localparam int VW_RAW = $clog2(V_TOTAL + 1);
    localparam int HW     = (HW_RAW > CHK_LOG2) ? HW_RAW : CHK_LOG2 + 1;
    localparam int VW     = (VW_RAW > CHK_LOG2) ? VW_RAW : CHK_LOG2 + 1;

    localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam bit BARS_EN = (H_ACTIVE >= 8);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BAR_LAST  = HW'(BAR_W - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [DW-1:0] FULL = {DW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [HW-1:0]   bar_pos;
    logic [3:0]      bar_idx;
    logic [2:0]      mode_q;
    logic [3*DW-1:0] solid_q;

    logic            active;
    logic            h_end;
    logic            v_end;
    logic            frame_end;
    logic            at_origin;

    logic [2:0]      mode_eff;
    logic [3*DW-1:0] solid_eff;
    logic            de_c;
    logic            hs_c;
    logic            vs_c;
    logic            sof_c;
    logic [DW-1:0]   r_c;
    logic [DW-1:0]   g_c;
    logic [DW-1:0]   b_c;

    assign active    = (state_q != IDLE);
    assign h_end     = (h_cnt == H_LAST);
    assign v_end     = (v_cnt == V_LAST);
    assign frame_end = active && h_end && v_end;
    assign at_origin = (state_q == RUN) && (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame in progress always runs to its last pixel; the enable is only honoured at frame end.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (I_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!I_en) begin
                    state_d = frame_end ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (I_en) begin
                    state_d = RUN;
                end else if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!active) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Bar index tracks h_cnt by counting pixels within each bar; index 8 marks the black remainder.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (!active || h_end) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (!bar_idx[3]) begin
            if (bar_pos == BAR_LAST) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (at_origin) begin
            mode_q  <= I_mode;
            solid_q <= I_solid_rgb;
        end
    end

    // The first pixel of a frame must already use the freshly sampled mode and colour.
    always_comb begin
        mode_eff  = at_origin ? I_mode : mode_q;
        solid_eff = at_origin ? I_solid_rgb : solid_q;
        de_c      = active && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_c      = (active && (h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
        vs_c      = (active && (v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
        sof_c     = at_origin;
        r_c       = '0;
        g_c       = '0;
        b_c       = '0;
        if (de_c) begin
            case (mode_eff)
                3'd0: begin
                    if (BARS_EN && !bar_idx[3]) begin
                        r_c = {DW{~bar_idx[1]}};
                        g_c = {DW{~bar_idx[2]}};
                        b_c = {DW{~bar_idx[0]}};
                    end
                end
                3'd1: begin
                    r_c = DW'(h_cnt);
                    g_c = DW'(h_cnt);
                    b_c = DW'(h_cnt);
                end
                3'd2: begin
                    if (h_cnt[CHK_LOG2] == v_cnt[CHK_LOG2]) begin
                        r_c = FULL;
                        g_c = FULL;
                        b_c = FULL;
                    end
                end
                3'd3: begin
                    {r_c, g_c, b_c} = solid_eff;
                end
                default: begin
                    r_c = '0;
                    g_c = '0;
                    b_c = '0;
                end
            endcase
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rgb_de <= 1'b0;
            O_rgb_hs <= ~HS_POL;
            O_rgb_vs <= ~VS_POL;
            O_sof    <= 1'b0;
            O_rgb_r  <= '0;
            O_rgb_g  <= '0;
            O_rgb_b  <= '0;
        end else begin
            O_rgb_de <= de_c;
            O_rgb_hs <= hs_c;
            O_rgb_vs <= vs_c;
            O_sof    <= sof_c;
            O_rgb_r  <= r_c;
            O_rgb_g  <= g_c;
            O_rgb_b  <= b_c;
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_frame_cnt <= '0;
        end else if (frame_end) begin
            O_frame_cnt <= O_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed and random enable/mode sequences compared every clock
// against a model that tracks only the linear raster position of the frame in progress.
module tb_video_pattern_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int DW       = 8;
    localparam int CHK_LOG2 = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic        pxl_clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  mode;
    logic [23:0] solid_rgb;
    logic        rgb_vs;
    logic        rgb_hs;
    logic        rgb_de;
    logic [7:0]  rgb_r;
    logic [7:0]  rgb_g;
    logic [7:0]  rgb_b;
    logic        sof;
    logic [15:0] frame_cnt;

    video_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .DW(DW), .CHK_LOG2(CHK_LOG2)
    ) dut (
        .I_pxl_clk(pxl_clk),
        .I_rst_n(rst_n),
        .I_en(en),
        .I_mode(mode),
        .I_solid_rgb(solid_rgb),
        .O_rgb_vs(rgb_vs),
        .O_rgb_hs(rgb_hs),
        .O_rgb_de(rgb_de),
        .O_rgb_r(rgb_r),
        .O_rgb_g(rgb_g),
        .O_rgb_b(rgb_b),
        .O_sof(sof),
        .O_frame_cnt(frame_cnt)
    );

    always #5 pxl_clk = ~pxl_clk;

    int          compare_count = 0;
    int          mismatch_count = 0;
    int          cur_pos = -1;
    int          frame_mode = 0;
    logic [23:0] frame_solid = '0;
    logic [15:0] frame_cnt_model = '0;
    logic [23:0] bar_rgb [8];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Raster position p (-1 when idle) is decoded into line/pixel and the colour rules applied.
    task automatic expectedAt(input int p, output logic e_de, output logic e_hs, output logic e_vs,
                              output logic e_sof, output logic [23:0] e_rgb);
        int h;
        int v;
        int bar;
        e_de  = 1'b0;
        e_hs  = 1'b0;
        e_vs  = 1'b0;
        e_sof = 1'b0;
        e_rgb = '0;
        if (p >= 0) begin
            h     = p % H_TOTAL;
            v     = p / H_TOTAL;
            e_de  = (h < H_ACTIVE) && (v < V_ACTIVE);
            e_hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
            e_vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
            e_sof = (p == 0);
            if (e_de) begin
                case (frame_mode)
                    0: begin
                        bar   = h / (H_ACTIVE / 8);
                        e_rgb = (bar < 8) ? bar_rgb[bar] : 24'h000000;
                    end
                    1: e_rgb = {3{h[7:0]}};
                    2: e_rgb = ((((h >> CHK_LOG2) ^ (v >> CHK_LOG2)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
                    3: e_rgb = frame_solid;
                    default: e_rgb = 24'h000000;
                endcase
            end
        end
    endtask

    task automatic clockAndCheck();
        logic        e_de;
        logic        e_hs;
        logic        e_vs;
        logic        e_sof;
        logic [23:0] e_rgb;
        int          prev;
        @(posedge pxl_clk);
        prev = cur_pos;
        if (prev == 0) begin
            frame_mode  = int'(mode);
            frame_solid = solid_rgb;
        end
        expectedAt(prev, e_de, e_hs, e_vs, e_sof, e_rgb);
        if (prev < 0) begin
            cur_pos = en ? 0 : -1;
        end else if (prev == FRAME - 1) begin
            frame_cnt_model = frame_cnt_model + 16'd1;
            cur_pos = en ? 0 : -1;
        end else begin
            cur_pos = prev + 1;
        end
        #1;
        checkOutput("de", 32'(rgb_de), 32'(e_de));
        checkOutput("hs", 32'(rgb_hs), 32'(e_hs));
        checkOutput("vs", 32'(rgb_vs), 32'(e_vs));
        checkOutput("sof", 32'(sof), 32'(e_sof));
        checkOutput("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(e_rgb));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(frame_cnt_model));
    endtask

    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [23:0] s, input int cycles);
        en        = e;
        mode      = m;
        solid_rgb = s;
        repeat (cycles) clockAndCheck();
    endtask

    // Called one tick after an edge; reset drops mid-cycle so the response must be asynchronous.
    task automatic resetMidLine();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_de", 32'(rgb_de), 32'd0);
        checkOutput("rst_hs", 32'(rgb_hs), 32'd0);
        checkOutput("rst_vs", 32'(rgb_vs), 32'd0);
        checkOutput("rst_sof", 32'(sof), 32'd0);
        checkOutput("rst_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        cur_pos         = -1;
        frame_cnt_model = '0;
        frame_mode      = 0;
        en              = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bar_rgb   = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        rst_n     = 1'b1;
        en        = 1'b0;
        mode      = 3'd0;
        solid_rgb = '0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("init_de", 32'(rgb_de), 32'd0);
        checkOutput("init_hs", 32'(rgb_hs), 32'd0);
        checkOutput("init_vs", 32'(rgb_vs), 32'd0);
        checkOutput("init_frame_cnt", 32'(frame_cnt), 32'd0);
        @(posedge pxl_clk);
        #1 rst_n = 1'b1;

        applyStimulus(1'b0, 3'd0, 24'h0, 5);
        applyStimulus(1'b1, 3'd0, 24'h0, 2 * FRAME);
        applyStimulus(1'b1, 3'd1, 24'h0, FRAME);
        applyStimulus(1'b1, 3'd2, 24'h0, FRAME);

        // Mode change to solid lands on line 2 of a bar frame.
        applyStimulus(1'b1, 3'd0, 24'h0, FRAME + 2 * H_TOTAL);
        applyStimulus(1'b1, 3'd3, 24'h123456, 2 * FRAME);

        applyStimulus(1'b0, 3'd3, 24'h123456, FRAME + 10);
        applyStimulus(1'b1, 3'd0, 24'h0, H_TOTAL + 6);
        applyStimulus(1'b0, 3'd0, 24'h0, FRAME + 10);
        applyStimulus(1'b1, 3'd2, 24'h0, 20);

        for (int seg = 0; seg < 24; seg++) begin
            applyStimulus(logic'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          24'($urandom), int'($urandom_range(1, 160)));
        end

        applyStimulus(1'b0, 3'd0, 24'h0, FRAME + 5);
        applyStimulus(1'b1, 3'd1, 24'h0, 30);
        resetMidLine();
        applyStimulus(1'b0, 3'd1, 24'h0, 20);

        applyStimulus(1'b1, 3'd1, 24'h0, 50);
        force dut.O_frame_cnt = 16'hFFFF;
        #1;
        release dut.O_frame_cnt;
        frame_cnt_model = 16'hFFFF;
        applyStimulus(1'b1, 3'd1, 24'h0, FRAME + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

    initial begin
        #1_000_000;
        mismatch_count++;
        $display("[TB] FAIL timeout: got no end of stimulus expected completion before 1000000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
